// File: rtl/ram_tp_arbiter.sv
// ram_tp_arbiter: shares one two-port bitmask RAM (one write port, one
// registered read port) among NUM_REQ requesters. After reset it sweeps every
// word to INIT_VALUE. It then arbitrates the write port and the read port
// independently, each round-robin, so one write and one read can complete in
// every cycle.
//
// Handshake: a requester presents req_valid with its fields held stable. A
// command is taken on the rising edge where req_valid[i] & req_ready[i] are
// both high. req_ready is combinational from req_valid, req_write and the
// round-robin pointers. A requester must not make req_valid depend on
// req_ready. A read taken at edge N returns its data in the cycle after
// edge N: rsp_valid carries a one-hot requester tag, and rsp_data is the RAM's
// registered output passed straight through.
module ram_tp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic                          init_busy,
  output logic                          dbg_state,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bwen,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_cen,
  output logic                          ram_wen,
  output logic                          ram_ren,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic [DATA_WIDTH-1:0]         ram_bwen,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  init_cnt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  logic [NUM_REQ-1:0]     wr_cand;
  logic [NUM_REQ-1:0]     rd_cand;
  logic                   wr_gnt;
  logic                   rd_gnt;
  logic [PTR_W-1:0]       wr_idx;
  logic [PTR_W-1:0]       rd_idx;
  logic [NUM_REQ-1:0]     wr_onehot;
  logic [NUM_REQ-1:0]     rd_onehot;

  // Returns {found, index} of the first set candidate at or after ptr,
  // scanning upward and wrapping. Scanning from the farthest offset down
  // lets the nearest candidate overwrite the others, so no early exit is needed.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0]   pick;
    logic [PTR_W-1:0] sel;
    int               idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = idx[PTR_W-1:0];
      if (cand[sel]) pick = {1'b1, sel};
    end
    return pick;
  endfunction

  // Pointer moves to the requester just after the one granted, wrapping.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    if (idx == PTR_W'(NUM_REQ - 1)) nxt = '0;
    else                            nxt = idx + PTR_W'(1);
    return nxt;
  endfunction

  // FSM state register; reset always restarts the init sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Next state: leave INIT on the edge where the last word is being cleared.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
      state_nxt = ST_RUN;
    end
  end

  // Candidate sets and round-robin grants for each port; nothing is granted
  // while the sweep owns the write port.
  always_comb begin
    wr_cand = '0;
    rd_cand = '0;
    if (state == ST_RUN) begin
      wr_cand = req_valid & req_write;
      rd_cand = req_valid & ~req_write;
    end
    {wr_gnt, wr_idx} = rr_pick(wr_cand, wr_ptr);
    {rd_gnt, rd_idx} = rr_pick(rd_cand, rd_ptr);
    wr_onehot = wr_gnt ? (NUM_REQ'(1) << wr_idx) : '0;
    rd_onehot = rd_gnt ? (NUM_REQ'(1) << rd_idx) : '0;
  end

  // Output decode: the sweep drives the write port in INIT; the granted
  // requesters drive the ports in RUN. Idle ports drive zeros.
  always_comb begin
    init_busy = (state == ST_INIT);
    dbg_state = state;
    req_ready = wr_onehot | rd_onehot;
    ram_wen   = 1'b0;
    ram_ren   = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_wdata = '0;
    ram_bwen  = '0;
    if (state == ST_INIT) begin
      ram_wen   = 1'b1;
      ram_waddr = init_cnt;
      ram_wdata = INIT_VALUE;
      ram_bwen  = '1;
    end else begin
      if (wr_gnt) begin
        ram_wen   = 1'b1;
        ram_waddr = req_addr[int'(wr_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = req_wdata[int'(wr_idx) * DATA_WIDTH +: DATA_WIDTH];
        ram_bwen  = req_bwen[int'(wr_idx) * DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt) begin
        ram_ren   = 1'b1;
        ram_raddr = req_addr[int'(rd_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    ram_cen = ram_wen | ram_ren;
  end

  // Read data needs no local storage: the RAM output register already lines
  // up with the response strobe.
  assign rsp_data = ram_rdata;

  // Sweep counter, round-robin pointers and the response tag. Reset drops any
  // response in flight and restarts the sweep at address 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
      if (wr_gnt) wr_ptr <= ptr_after(wr_idx);
      if (rd_gnt) rd_ptr <= ptr_after(rd_idx);
      rsp_valid <= rd_onehot;
    end
  end

endmodule

// File: tb/tb_ram_tp_arbiter.sv
// Directed bench for ram_tp_arbiter with a behavioural two-port bitmask RAM
// (registered read, read returns the pre-write word on a same-address clash).
module tb_ram_tp_arbiter;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam logic [DW-1:0] INIT_V = 32'hA5A5_A5A5;

  logic               clock;
  logic               reset_n;
  logic               init_busy;
  logic               dbg_state;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_write;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR*DW-1:0]   req_bwen;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               ram_cen;
  logic               ram_wen;
  logic               ram_ren;
  logic [AW-1:0]      ram_waddr;
  logic [AW-1:0]      ram_raddr;
  logic [DW-1:0]      ram_wdata;
  logic [DW-1:0]      ram_bwen;
  logic [DW-1:0]      ram_rdata;

  int vectors = 0;
  int errors  = 0;

  ram_tp_arbiter #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR), .INIT_VALUE(INIT_V)
  ) dut (
    .clock(clock), .reset_n(reset_n), .init_busy(init_busy), .dbg_state(dbg_state),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bwen(req_bwen), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_cen(ram_cen),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_bwen(ram_bwen),
    .ram_rdata(ram_rdata)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_cen && ram_wen)
      mem[ram_waddr] <= (mem[ram_waddr] & ~ram_bwen) | (ram_wdata & ram_bwen);
    if (ram_cen && ram_ren)
      ram_rdata <= mem[ram_raddr];
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] bw);
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_bwen[r*DW +: DW] = bw;
  endtask

  task automatic clr_req(input int r);
    req_valid[r] = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic do_read(input int r, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [NR-1:0] oh;
    oh = 4'b0001 << r;
    set_req(r, 1'b0, a, '0, '0);
    @(negedge clock);
    chk("rd_ready", req_ready, oh);
    chk("rd_ren", ram_ren, 1'b1);
    chk("rd_raddr", ram_raddr, a);
    @(posedge clock); #1;
    clr_req(r);
    @(negedge clock);
    chk("rd_rsp_valid", rsp_valid, oh);
    chk("rd_rsp_data", rsp_data, exp);
    @(posedge clock); #1;
  endtask

  task automatic do_write(input int r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] bw);
    logic [NR-1:0] oh;
    oh = 4'b0001 << r;
    set_req(r, 1'b1, a, d, bw);
    @(negedge clock);
    chk("wr_ready", req_ready, oh);
    chk("wr_wen", ram_wen, 1'b1);
    chk("wr_waddr", ram_waddr, a);
    chk("wr_wdata", ram_wdata, d);
    chk("wr_bwen", ram_bwen, bw);
    @(posedge clock); #1;
    clr_req(r);
  endtask

  // Called at posedge+1 right after reset release; returns at a negedge in RUN.
  task automatic init_sweep(input string tag);
    int n;
    int guard;
    n = 0;
    guard = 0;
    req_valid = '1;
    req_write = '0;
    while (guard < 40) begin
      @(negedge clock);
      guard++;
      if (!init_busy) break;
      chk({tag, "_waddr"}, ram_waddr, n);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_rsp"}, rsp_valid, 0);
      chk({tag, "_wdata"}, ram_wdata, INIT_V);
      n++;
    end
    req_valid = '0;
    chk({tag, "_len"}, n, 16);
    chk({tag, "_state"}, dbg_state, 1'b1);
  endtask

  initial begin
    logic [NR-1:0] oh;
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_bwen  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_waddr", ram_waddr, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_sweep("init1");

    // Idle RUN: no enables
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_cen", ram_cen, 1'b0);
    chk("idle_ready", req_ready, 0);
    @(posedge clock); #1;

    // Every word holds the init value
    for (int a = 0; a < DEPTH; a++) do_read(0, a[AW-1:0], INIT_V);

    // Bitmask write by requester 1 over A5A5A5A5
    do_write(1, 4'd3, 32'hFFFF_FFFF, 32'h0000_FF00);
    do_read(1, 4'd3, 32'hA5A5_FFA5);

    // Same-cycle write (req 0) and read (req 2) of address 5
    set_req(0, 1'b1, 4'd5, 32'h1234_5678, 32'hFFFF_FFFF);
    set_req(2, 1'b0, 4'd5, '0, '0);
    @(negedge clock);
    chk("cc_ready", req_ready, 4'b0101);
    chk("cc_cen", ram_cen, 1'b1);
    chk("cc_waddr", ram_waddr, 4'd5);
    chk("cc_raddr", ram_raddr, 4'd5);
    @(posedge clock); #1;
    clr_req(0);
    clr_req(2);
    @(negedge clock);
    chk("cc_rsp_valid", rsp_valid, 4'b0100);
    chk("cc_rsp_data", rsp_data, INIT_V);
    @(posedge clock); #1;
    do_read(2, 4'd5, 32'h1234_5678);

    // Read contention with rd_ptr at 3: req 3 first, then wrap to req 0
    set_req(0, 1'b0, 4'd5, '0, '0);
    set_req(3, 1'b0, 4'd3, '0, '0);
    @(negedge clock);
    chk("rc_ready1", req_ready, 4'b1000);
    @(posedge clock); #1;
    clr_req(3);
    @(negedge clock);
    chk("rc_ready2", req_ready, 4'b0001);
    chk("rc_rsp_valid1", rsp_valid, 4'b1000);
    chk("rc_rsp_data1", rsp_data, 32'hA5A5_FFA5);
    @(posedge clock); #1;
    clr_req(0);
    @(negedge clock);
    chk("rc_rsp_valid2", rsp_valid, 4'b0001);
    chk("rc_rsp_data2", rsp_data, 32'h1234_5678);
    @(posedge clock); #1;

    // Write by req 3 moves wr_ptr (currently 1) to 0
    do_write(3, 4'd15, 32'h0000_0000, 32'hFFFF_FFFF);

    // All four writers held: grants 0,1,2,3,0
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, 4'd8 + 4'(i), 32'hC0DE_0000 + i, 32'hFFFF_FFFF);
    for (int c = 0; c < 5; c++) begin
      oh = 4'b0001 << (c % 4);
      @(negedge clock);
      chk("rr_ready", req_ready, oh);
      chk("rr_waddr", ram_waddr, 8 + (c % 4));
      @(posedge clock); #1;
    end
    req_valid = '0;
    do_read(1, 4'd9, 32'hC0DE_0001);
    do_read(2, 4'd11, 32'hC0DE_0003);
    do_read(3, 4'd15, 32'h0000_0000);

    // Reset the cycle after a read handshake: response dropped at once
    set_req(1, 1'b0, 4'd8, '0, '0);
    @(posedge clock); #1;
    clr_req(1);
    chk("mr_rsp_before", rsp_valid, 4'b0010);
    reset_n = 1'b0;
    #1;
    chk("mr_rsp_dropped", rsp_valid, 0);
    chk("mr_busy", init_busy, 1'b1);
    @(negedge clock);
    chk("mr_rsp_held", rsp_valid, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_sweep("init2");

    // Reset during the sweep at init_cnt = 7: restart from 0
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    chk("mi_waddr7", ram_waddr, 4'd7);
    reset_n = 1'b0;
    #1;
    chk("mi_waddr0", ram_waddr, 4'd0);
    chk("mi_busy", init_busy, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_sweep("init3");
    @(posedge clock); #1;
    do_read(0, 4'd3, INIT_V);
    do_read(2, 4'd5, INIT_V);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
